// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter
//   Shares one external memory burst port between the I-cache refill path
//   (read only) and the D-cache refill / write-back path (read or write).
//   One owner is granted at a time; each grant runs exactly one burst of
//   LINE_WORDS beats, then pulses the owner's done strobe for one cycle.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_req/i_addr                  I-cache line read request (level)
//   i_rvalid/i_rdata/i_done       read beats and completion to the I-cache
//   d_req/d_we/d_addr/d_wdata     D-cache request, direction, address, write beat
//   d_wready                      current D write beat consumed this cycle
//   d_rvalid/d_rdata/d_done       read beats and completion to the D-cache
//   mem_cmd_*                     burst command handshake to memory
//   mem_wvalid/mem_wready/mem_wdata  write beat handshake to memory
//   mem_rvalid/mem_rdata          read beats from memory
//   busy/owner                    arbiter status (owner: 0 = I, 1 = D)

module cache_refill_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // I-cache side
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_done,
    // D-cache side
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_wready,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    // memory side
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic                  mem_cmd_we,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    // status
    output logic                  busy,
    output logic                  owner
);

    localparam int              CW        = $clog2(LINE_WORDS);
    localparam logic [CW-1:0]   LAST_BEAT = CW'(LINE_WORDS - 1);

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RDATA,
        S_WDATA,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic                  pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_I;
            // last_owner starts as D so the I-cache wins the first tie
            last_owner_q <= OWN_D;
            we_q         <= 1'b0;
            addr_q       <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        // next-state defaults: hold
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        beat_cnt_d   = beat_cnt_q;
        pick         = OWN_I;

        // output defaults: everything quiet
        busy          = (state_q != S_IDLE);
        owner         = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_cmd_addr  = '0;
        mem_cmd_we    = 1'b0;
        mem_wvalid    = 1'b0;
        mem_wdata     = '0;
        d_wready      = 1'b0;
        i_rvalid      = 1'b0;
        i_rdata       = '0;
        d_rvalid      = 1'b0;
        d_rdata       = '0;
        i_done        = 1'b0;
        d_done        = 1'b0;

        // latched burst attributes are visible for the whole transaction
        if (busy) begin
            owner        = owner_q;
            mem_cmd_addr = addr_q;
            mem_cmd_we   = we_q;
        end

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    // a tie goes to whoever did not own the previous burst,
                    // which makes grants alternate under steady contention
                    pick    = (i_req && d_req) ? ~last_owner_q : d_req;
                    owner_d = pick;
                    addr_d  = (pick == OWN_D) ? d_addr : i_addr;
                    we_d    = (pick == OWN_D) & d_we;   // I-cache only reads
                    state_d = S_CMD;
                end
            end

            S_CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    state_d = we_q ? S_WDATA : S_RDATA;
                end
            end

            S_RDATA: begin
                // beats are routed straight through; only the owner sees them
                if (owner_q == OWN_D) begin
                    d_rvalid = mem_rvalid;
                    d_rdata  = mem_rdata;
                end else begin
                    i_rvalid = mem_rvalid;
                    i_rdata  = mem_rdata;
                end
                if (mem_rvalid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_WDATA: begin
                // writes are only ever granted to the D-cache
                mem_wvalid = 1'b1;
                mem_wdata  = d_wdata;
                d_wready   = mem_wready & owner_q;
                if (mem_wready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // requests are not looked at here; the owner drops its
                // request in the following IDLE cycle
                i_done       = (owner_q == OWN_I);
                d_done       = (owner_q == OWN_D);
                last_owner_d = owner_q;
                beat_cnt_d   = '0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Testbench for cache_refill_arbiter: a directed vector table, hand-written
// multi-cycle sequences (tie alternation, command stall, reset mid-burst) and
// a randomized run checked against a transaction-level reference model.

module tb_cache_refill_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_rvalid, i_done;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_wready, d_rvalid, d_done;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic          mem_wvalid, mem_wready, mem_rvalid;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, owner;

    always #5 clk = ~clk;

    cache_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_we(mem_cmd_we), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic          cv;
        logic [AW-1:0] ca;
        logic          cwe;
        logic          wv;
        logic [DW-1:0] wd;
        logic          dwr;
        logic          irv;
        logic [DW-1:0] ird;
        logic          idn;
        logic          drv;
        logic [DW-1:0] drd;
        logic          ddn;
        logic          bsy;
        logic          own;
    } outs_t;

    typedef struct {
        logic          ireq;
        logic [AW-1:0] iaddr;
        logic          dreq;
        logic          dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwdata;
        logic          crdy;
        logic          rv;
        logic [DW-1:0] rd;
        logic          wrdy;
    } ins_t;

    typedef struct {
        ins_t  stim;
        outs_t exp_o;
    } vec_t;

    function automatic outs_t cur_outs();
        outs_t o;
        o.cv = mem_cmd_valid; o.ca = mem_cmd_addr; o.cwe = mem_cmd_we;
        o.wv = mem_wvalid;    o.wd = mem_wdata;    o.dwr = d_wready;
        o.irv = i_rvalid;     o.ird = i_rdata;     o.idn = i_done;
        o.drv = d_rvalid;     o.drd = d_rdata;     o.ddn = d_done;
        o.bsy = busy;         o.own = owner;
        return o;
    endfunction

    function automatic ins_t mk_in(bit ireq, logic [AW-1:0] iaddr, bit dreq, bit dwe,
                                   logic [AW-1:0] daddr, logic [DW-1:0] dwdata,
                                   bit crdy, bit rv, logic [DW-1:0] rd, bit wrdy);
        ins_t s;
        s.ireq = ireq; s.iaddr = iaddr; s.dreq = dreq; s.dwe = dwe; s.daddr = daddr;
        s.dwdata = dwdata; s.crdy = crdy; s.rv = rv; s.rd = rd; s.wrdy = wrdy;
        return s;
    endfunction

    function automatic outs_t mk_out(bit cv, logic [AW-1:0] ca, bit cwe, bit wv,
                                     logic [DW-1:0] wd, bit dwr, bit irv, logic [DW-1:0] ird,
                                     bit idn, bit drv, logic [DW-1:0] drd, bit ddn,
                                     bit bsy, bit own);
        outs_t o;
        o.cv = cv; o.ca = ca; o.cwe = cwe; o.wv = wv; o.wd = wd; o.dwr = dwr;
        o.irv = irv; o.ird = ird; o.idn = idn; o.drv = drv; o.drd = drd; o.ddn = ddn;
        o.bsy = bsy; o.own = own;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input ins_t s);
        i_req = s.ireq; i_addr = s.iaddr;
        d_req = s.dreq; d_we = s.dwe; d_addr = s.daddr; d_wdata = s.dwdata;
        mem_cmd_ready = s.crdy; mem_rvalid = s.rv; mem_rdata = s.rd; mem_wready = s.wrdy;
    endtask

    task automatic idle_inputs();
        apply(mk_in(0, '0, 0, 0, '0, '0, 0, 0, '0, 0));
    endtask

    // inputs change 1 time unit after the rising edge; outputs are read at
    // the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // leaves the bench just after a rising edge, reset released, inputs idle
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        settle();
        chk("reset_outs", cur_outs(), '0);
        next_cycle();
        rst = 1'b0;
    endtask

    vec_t tv[18];

    // random-run state
    bit            ipend, dpend, m_own, m_we, m_last, exp_own;
    bit            prev_idle_req, prev_i, prev_d;
    int            icool, dcool, dwidx, ph, ph_n, m_beats;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] dline[LW];

    initial begin
        bit            wr_pat[6];
        logic [DW-1:0] wd_pat[6];
        bit            grants[6];
        int            ng, nd, beats;
        bit            seen_done, addr_seen;

        // ---------------- vector table ----------------
        wr_pat = '{1, 0, 1, 1, 0, 1};
        wd_pat = '{32'hB0, 32'hB1, 32'hB1, 32'hB2, 32'hB3, 32'hB3};

        // lone I read at 0x100 with spurious rvalid in IDLE, CMD and DONE
        tv[0] = '{mk_in(1, 32'h100, 0, 0, '0, '0, 1, 1, 32'hEE, 0),
                  mk_out(0, '0, 0, 0, '0, 0, 0, '0, 0, 0, '0, 0, 0, 0)};
        tv[1] = '{mk_in(1, 32'h100, 0, 0, '0, '0, 1, 1, 32'hEE, 0),
                  mk_out(1, 32'h100, 0, 0, '0, 0, 0, '0, 0, 0, '0, 0, 1, 0)};
        for (int k = 0; k < 4; k++) begin
            tv[2+k] = '{mk_in(1, 32'h100, 0, 0, '0, '0, 1, 1, 32'hA0 + k, 0),
                        mk_out(0, 32'h100, 0, 0, '0, 0, 1, 32'hA0 + k, 0, 0, '0, 0, 1, 0)};
        end
        tv[6] = '{mk_in(1, 32'h100, 0, 0, '0, '0, 1, 1, 32'hEE, 0),
                  mk_out(0, 32'h100, 0, 0, '0, 0, 0, '0, 1, 0, '0, 0, 1, 0)};
        tv[7] = '{mk_in(0, '0, 0, 0, '0, '0, 0, 0, '0, 0),
                  mk_out(0, '0, 0, 0, '0, 0, 0, '0, 0, 0, '0, 0, 0, 0)};
        // lone D write-back at 0x200, wready 1,0,1,1,0,1
        tv[8] = '{mk_in(0, '0, 1, 1, 32'h200, 32'hB0, 1, 0, '0, 0),
                  mk_out(0, '0, 0, 0, '0, 0, 0, '0, 0, 0, '0, 0, 0, 0)};
        tv[9] = '{mk_in(0, '0, 1, 1, 32'h200, 32'hB0, 1, 0, '0, 0),
                  mk_out(1, 32'h200, 1, 0, '0, 0, 0, '0, 0, 0, '0, 0, 1, 1)};
        for (int k = 0; k < 6; k++) begin
            tv[10+k] = '{mk_in(0, '0, 1, 1, 32'h200, wd_pat[k], 1, 0, '0, wr_pat[k]),
                         mk_out(0, 32'h200, 1, 1, wd_pat[k], wr_pat[k], 0, '0, 0, 0, '0, 0, 1, 1)};
        end
        tv[16] = '{mk_in(0, '0, 1, 1, 32'h200, 32'hB3, 1, 0, '0, 1),
                   mk_out(0, 32'h200, 1, 0, '0, 0, 0, '0, 0, 0, '0, 1, 1, 1)};
        tv[17] = '{mk_in(0, '0, 0, 0, '0, '0, 0, 0, '0, 0),
                   mk_out(0, '0, 0, 0, '0, 0, 0, '0, 0, 0, '0, 0, 0, 0)};

        do_reset();
        for (int k = 0; k < 18; k++) begin
            if (k > 0) next_cycle();
            apply(tv[k].stim);
            settle();
            chk($sformatf("vec[%0d]", k), cur_outs(), tv[k].exp_o);
        end

        // ---------------- tie: both held, grants alternate ----------------
        do_reset();
        ng = 0; nd = 0;
        for (int c = 0; c < 200 && nd < 6; c++) begin
            if (c > 0) next_cycle();
            i_req = 1'b1; i_addr = 32'h600;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
            mem_cmd_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'(c); mem_wready = 1'b1;
            settle();
            if (mem_cmd_valid && mem_cmd_ready && ng < 6) begin
                grants[ng] = owner;
                ng++;
            end
            if (i_done || d_done) nd++;
        end
        next_cycle();
        idle_inputs();
        settle();
        chk("tie_grant_count", 192'(ng), 192'(6));
        for (int k = 0; k < 6 && k < ng; k++) begin
            chk($sformatf("tie_grant[%0d]", k), 192'(grants[k]), 192'(k % 2));
        end

        // ---------------- command stall ----------------
        do_reset();
        i_req = 1'b1; i_addr = 32'h340; mem_rvalid = 1'b1; mem_rdata = 32'hC0;
        settle();
        for (int s = 0; s < 5; s++) begin
            next_cycle();
            settle();
            chk($sformatf("stall_cv[%0d]", s), 192'(mem_cmd_valid), 192'(1));
            chk($sformatf("stall_addr[%0d]", s), 192'(mem_cmd_addr), 192'(32'h340));
            chk($sformatf("stall_rv[%0d]", s), 192'(i_rvalid), 192'(0));
        end
        next_cycle();
        mem_cmd_ready = 1'b1;
        settle();
        chk("stall_accept_cv", 192'(mem_cmd_valid), 192'(1));
        chk("stall_accept_rv", 192'(i_rvalid), 192'(0));
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            mem_cmd_ready = 1'b0;
            mem_rdata = 32'hC0 + b;
            settle();
            chk($sformatf("stall_beat[%0d]", b), 192'({i_rvalid, i_rdata}), 192'({1'b1, 32'hC0 + b}));
        end
        next_cycle();
        mem_rvalid = 1'b0;
        settle();
        chk("stall_done", 192'({i_done, d_done}), 192'(2'b10));
        next_cycle();
        idle_inputs();
        settle();
        chk("stall_idle", 192'(busy), 192'(0));

        // ---------------- reset mid-burst ----------------
        do_reset();
        i_req = 1'b1; i_addr = 32'h400; mem_cmd_ready = 1'b1;
        settle();
        next_cycle();
        settle();
        for (int b = 0; b < 2; b++) begin
            next_cycle();
            mem_rvalid = 1'b1; mem_rdata = 32'hD0 + b;
            settle();
            chk($sformatf("pre_rst_beat[%0d]", b), 192'(i_rvalid), 192'(1));
        end
        next_cycle();
        rst = 1'b1; i_req = 1'b0;
        settle();
        next_cycle();
        rst = 1'b0;
        settle();
        chk("rst_mid_outs", cur_outs(), '0);
        next_cycle();
        i_req = 1'b1; i_addr = 32'h500;
        settle();
        beats = 0; seen_done = 1'b0; addr_seen = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            next_cycle();
            mem_rdata = 32'hE0 + c;
            settle();
            if (mem_cmd_valid && !addr_seen) begin
                addr_seen = 1'b1;
                chk("rst_new_addr", 192'(mem_cmd_addr), 192'(32'h500));
            end
            if (i_rvalid) beats++;
            if (i_done) seen_done = 1'b1;
        end
        chk("rst_new_done", 192'(seen_done), 192'(1));
        chk("rst_new_beats", 192'(beats), 192'(4));
        next_cycle();
        idle_inputs();
        settle();

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        ipend = 0; dpend = 0; icool = 0; dcool = 0; dwidx = 0;
        ph = 0; m_beats = 0; m_last = 1'b1; m_own = 0; m_we = 0; m_addr = '0;
        prev_idle_req = 0; prev_i = 0; prev_d = 0;
        for (int k = 0; k < LW; k++) dline[k] = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) next_cycle();
            // requester agents: hold the request until done, drop it after
            if (icool > 0) icool--;
            else if (!ipend && $urandom_range(0, 3) == 0) begin
                ipend = 1'b1;
                i_addr = $urandom & ~32'hF;
            end
            if (dcool > 0) dcool--;
            else if (!dpend && $urandom_range(0, 3) == 0) begin
                dpend = 1'b1;
                d_addr = $urandom & ~32'hF;
                d_we = 1'($urandom_range(0, 1));
                for (int k = 0; k < LW; k++) dline[k] = $urandom;
                dwidx = 0;
            end
            i_req = ipend;
            d_req = dpend;
            d_wdata = (dwidx < LW) ? dline[dwidx] : '0;
            // memory: random readiness, spurious rvalid allowed at any time
            mem_cmd_ready = 1'($urandom_range(0, 1));
            mem_rvalid = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            mem_wready = 1'($urandom_range(0, 1));
            settle();

            // a request seen while free produces a command in the next cycle
            if (ph == 0 && prev_idle_req) begin
                exp_own = (prev_i && prev_d) ? ~m_last : prev_d;
                m_own = exp_own;
                m_addr = exp_own ? d_addr : i_addr;
                m_we = exp_own & d_we;
                m_beats = 0;
                ph = 1;
                chk("rnd_grant_owner", 192'(owner), 192'(m_own));
                chk("rnd_grant_we", 192'(mem_cmd_we), 192'(m_we));
            end
            ph_n = ph;
            case (ph)
                0: begin
                    chk("rnd_idle", 192'({busy, mem_cmd_valid}), 192'(0));
                end
                1: begin
                    chk("rnd_cmd", 192'({busy, owner, mem_cmd_valid, mem_cmd_addr}),
                        192'({1'b1, m_own, 1'b1, m_addr}));
                    if (mem_cmd_ready) ph_n = 2;
                end
                2: begin
                    chk("rnd_data_busy", 192'({busy, owner, mem_cmd_valid}), 192'({1'b1, m_own, 1'b0}));
                    if (!m_we) begin
                        chk("rnd_rv_owner", 192'(m_own ? d_rvalid : i_rvalid), 192'(mem_rvalid));
                        chk("rnd_rv_other", 192'(m_own ? i_rvalid : d_rvalid), 192'(0));
                        chk("rnd_rd_wside", 192'({mem_wvalid, d_wready}), 192'(0));
                        if (mem_rvalid) begin
                            chk("rnd_rdata", 192'(m_own ? d_rdata : i_rdata), 192'(mem_rdata));
                            m_beats++;
                        end
                    end else begin
                        chk("rnd_wvalid", 192'(mem_wvalid), 192'(1));
                        chk("rnd_wready", 192'(d_wready), 192'(mem_wready));
                        chk("rnd_wr_rside", 192'({i_rvalid, d_rvalid}), 192'(0));
                        if (mem_wready) begin
                            chk($sformatf("rnd_wdata[%0d]", m_beats), 192'(mem_wdata), 192'(dline[m_beats]));
                            m_beats++;
                        end
                        if (d_wready) dwidx++;
                    end
                    if (m_beats == LW) ph_n = 3;
                end
                default: begin
                    chk("rnd_done", 192'({i_done, d_done}), 192'(m_own ? 2'b01 : 2'b10));
                    m_last = m_own;
                    if (m_own) begin dpend = 1'b0; dcool = 1; end
                    else begin ipend = 1'b0; icool = 1; end
                    ph_n = 0;
                end
            endcase
            if (ph != 2) begin
                chk("rnd_quiet", 192'({i_rvalid, d_rvalid, d_wready, mem_wvalid}), 192'(0));
            end
            if (ph != 3) begin
                chk("rnd_no_done", 192'({i_done, d_done}), 192'(0));
            end
            prev_idle_req = (ph == 0) && (i_req || d_req);
            prev_i = i_req;
            prev_d = d_req;
            ph = ph_n;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
